burst_cmac: RTL and testbench

BURST_CMAC -- requirements
Module: burst_cmac

---
 rtl/burst_cmac.sv | 226 ++++++++++++++++++++++
 tb/tb_burst_cmac.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/burst_cmac.sv
// -----------------------------------------------------------------------------
// burst_cmac
//   Complex multiply-accumulate over bursts of up to 12 samples. Every accepted
//   sample is multiplied by its complex weight, and the products are summed per
//   burst. Each burst produces one rounded, saturated 9-bit complex result.
//
//   A burst closes on its 12th sample, or on the first cycle without a sample.
//   A 13th consecutive sample opens the next burst with no gap. A done pulse
//   stops sample intake and lets the pending burst drain. After that, out_done
//   pulses once and the block parks in FIN until reset.
//
//   Pipeline, counted from the edge that accepts a sample:
//     capture (sample + first/12th tags)
//       -> products + first/last tags
//       -> accumulate
//       -> output registers.
//   A burst's result is therefore strobed on the 3rd edge after the edge that
//   accepted its last sample.
//
// Ports
//   clk                       rising-edge clock
//   rstb                      synchronous active-low reset
//   in_data_i / in_data_q     12-bit signed sample (real / imaginary)
//   in_w_i / in_w_q           4-bit signed weight (real / imaginary)
//   in_en                     sample valid
//   done                      end-of-stimulus pulse
//   out_data_i / out_data_q   9-bit signed burst result, held between strobes
//   out_en                    one-cycle strobe for out_data_* and out_short
//   out_short                 burst had fewer than 12 samples
//   out_done                  one-cycle pulse: every result has been emitted
// -----------------------------------------------------------------------------
module burst_cmac (
  input  logic              clk,
  input  logic              rstb,
  input  logic signed [11:0] in_data_i,
  input  logic signed [11:0] in_data_q,
  input  logic signed [3:0]  in_w_i,
  input  logic signed [3:0]  in_w_q,
  input  logic              in_en,
  input  logic              done,
  output logic signed [8:0]  out_data_i,
  output logic signed [8:0]  out_data_q,
  output logic              out_en,
  output logic              out_short,
  output logic              out_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam logic [3:0] BURST_LEN = 4'd12;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       out_done_d;
  logic       accept, first, last12, pending;

  // Capture stage.
  logic              s0_v_q, s0_first_q, s0_last12_q;
  logic signed [11:0] s0_di_q, s0_dq_q;
  logic signed [3:0]  s0_wi_q, s0_wq_q;

  // Product stage.
  logic              s1_v_q, s1_first_q, s1_last_q, s1_short_q;
  logic signed [16:0] s1_pr_q, s1_pi_q;

  // Accumulate stage.
  logic              s2_close_q, s2_short_q;
  logic signed [20:0] s2_acc_r_q, s2_acc_m_q;

  // Product datapath (combinational, from the capture stage).
  logic signed [16:0] di_x, dq_x, wi_x, wq_x, pr_d, pi_d;
  logic signed [20:0] pr_x, pi_x;

  // Round half up, arithmetic shift by 10, then clamp to the 9-bit range.
  function automatic logic signed [8:0] round_sat(input logic signed [20:0] s);
    logic signed [20:0] r;
    r = (s + 21'sd512) >>> 10;
    if (r > 21'sd255)       return 9'sh0ff;
    else if (r < -21'sd256) return 9'sh100;
    else                    return r[8:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Controller: next-state logic
  // ---------------------------------------------------------------------------
  // Anything still in flight that could yet produce an out_en strobe.
  assign pending = s0_v_q | s1_v_q | s2_close_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case leaves a variable unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_done_d = 1'b0;
    accept     = in_en && (state_q == ST_IDLE || state_q == ST_ACC);
    // A sample after a full 12-sample burst starts a new burst.
    first      = accept && (state_q == ST_IDLE || cnt_q == BURST_LEN);
    last12     = accept && !first && (cnt_q == BURST_LEN - 4'd1);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ACC;
          cnt_d   = 4'd1;
        end
      end
      ST_ACC: begin
        if (accept) begin
          cnt_d = first ? 4'd1 : cnt_q + 4'd1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      ST_FLUSH: begin
        if (!pending) begin
          out_done_d = 1'b1;
          state_d    = ST_FIN;
        end
      end
      ST_FIN: ;
      default: state_d = ST_IDLE;
    endcase

    // Done takes priority over intake transitions. A sample on the same edge
    // has already been accepted above, and its burst closes on the next edge
    // because FLUSH accepts nothing.
    if (done && (state_q == ST_IDLE || state_q == ST_ACC)) begin
      state_d = ST_FLUSH;
      cnt_d   = 4'd0;
    end
  end

  always_comb begin
    di_x = {{5{s0_di_q[11]}}, s0_di_q};
    dq_x = {{5{s0_dq_q[11]}}, s0_dq_q};
    wi_x = {{13{s0_wi_q[3]}}, s0_wi_q};
    wq_x = {{13{s0_wq_q[3]}}, s0_wq_q};
    pr_d = di_x * wi_x - dq_x * wq_x;
    pi_d = di_x * wq_x + dq_x * wi_x;
    pr_x = {{4{s1_pr_q[16]}}, s1_pr_q};
    pi_x = {{4{s1_pi_q[16]}}, s1_pi_q};
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned only with non-blocking (<=), so every
  // stage samples the previous stage's pre-edge value.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      // NOTE: the datapath registers are reset along with the control bits.
      // Held outputs and accumulators then start from a defined zero, not X.
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      s0_v_q      <= 1'b0;
      s0_first_q  <= 1'b0;
      s0_last12_q <= 1'b0;
      s0_di_q     <= '0;
      s0_dq_q     <= '0;
      s0_wi_q     <= '0;
      s0_wq_q     <= '0;
      s1_v_q      <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_short_q  <= 1'b0;
      s1_pr_q     <= '0;
      s1_pi_q     <= '0;
      s2_close_q  <= 1'b0;
      s2_short_q  <= 1'b0;
      s2_acc_r_q  <= '0;
      s2_acc_m_q  <= '0;
      out_data_i  <= '0;
      out_data_q  <= '0;
      out_en      <= 1'b0;
      out_short   <= 1'b0;
      out_done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      // Capture stage.
      s0_v_q      <= accept;
      s0_first_q  <= first;
      s0_last12_q <= last12;
      if (accept) begin
        s0_di_q <= in_data_i;
        s0_dq_q <= in_data_q;
        s0_wi_q <= in_w_i;
        s0_wq_q <= in_w_q;
      end

      // Product stage. A sample is last either because it was the 12th, or
      // because nothing was accepted on the edge that follows it.
      s1_v_q     <= s0_v_q;
      s1_first_q <= s0_first_q;
      s1_last_q  <= s0_v_q & (s0_last12_q | ~accept);
      s1_short_q <= ~s0_last12_q;
      s1_pr_q    <= pr_d;
      s1_pi_q    <= pi_d;

      // Accumulate stage: the first sample loads the sum, the rest add to it.
      if (s1_v_q) begin
        s2_acc_r_q <= s1_first_q ? pr_x : s2_acc_r_q + pr_x;
        s2_acc_m_q <= s1_first_q ? pi_x : s2_acc_m_q + pi_x;
      end
      s2_close_q <= s1_v_q & s1_last_q;
      if (s1_v_q & s1_last_q) s2_short_q <= s1_short_q;

      // Output stage. Data and short flag hold between strobes.
      out_en <= s2_close_q;
      if (s2_close_q) begin
        out_data_i <= round_sat(s2_acc_r_q);
        out_data_q <= round_sat(s2_acc_m_q);
        out_short  <= s2_short_q;
      end
      out_done <= out_done_d;
    end
  end

endmodule

// File: tb/tb_burst_cmac.sv
// -----------------------------------------------------------------------------
// tb_burst_cmac
//   Directed testbench for burst_cmac. Stimulus is driven 1 ns after each rising
//   edge. A negedge monitor logs every out_en and out_done together with the
//   index of the rising edge that produced it. Expected values are hand-computed
//   constants.
// -----------------------------------------------------------------------------
module tb_burst_cmac;

  logic              clk = 1'b0;
  logic              rstb;
  logic signed [11:0] in_data_i, in_data_q;
  logic signed [3:0]  in_w_i, in_w_q;
  logic              in_en, done;
  logic signed [8:0]  out_data_i, out_data_q;
  logic              out_en, out_short, out_done;

  burst_cmac dut (
    .clk        (clk),
    .rstb       (rstb),
    .in_data_i  (in_data_i),
    .in_data_q  (in_data_q),
    .in_w_i     (in_w_i),
    .in_w_q     (in_w_q),
    .in_en      (in_en),
    .done       (done),
    .out_data_i (out_data_i),
    .out_data_q (out_data_q),
    .out_en     (out_en),
    .out_short  (out_short),
    .out_done   (out_done)
  );

  always #5 clk = ~clk;

  // Rising-edge index.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event logs.
  int en_cyc[$], en_i[$], en_q[$], en_s[$], dn_cyc[$];

  always @(negedge clk) begin
    if (out_en) begin
      en_cyc.push_back(cyc);
      en_i.push_back(int'(out_data_i));
      en_q.push_back(int'(out_data_q));
      en_s.push_back(int'(out_short));
    end
    if (out_done) dn_cyc.push_back(cyc);
  end

  int n_pass  = 0;
  int n_total = 0;
  int last_acc, l12, d_cyc;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clr();
    en_cyc.delete(); en_i.delete(); en_q.delete(); en_s.delete(); dn_cyc.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstb  = 1'b0;
    in_en = 1'b0;
    done  = 1'b0;
    tick(2);
    rstb = 1'b1;
    clr();
  endtask

  // One sample, optionally with done on the same edge.
  task automatic samp(input int di, input int dq, input int wi, input int wq, input logic dn);
    in_data_i = 12'(di);
    in_data_q = 12'(dq);
    in_w_i    = 4'(wi);
    in_w_q    = 4'(wq);
    in_en     = 1'b1;
    done      = dn;
    @(posedge clk);
    #1;
    last_acc = cyc;
    in_en    = 1'b0;
    done     = 1'b0;
  endtask

  task automatic burst(input int n, input int di, input int dq, input int wi, input int wq);
    for (int k = 0; k < n; k++) samp(di, dq, wi, wq, 1'b0);
  endtask

  task automatic pulse_done();
    in_en = 1'b0;
    done  = 1'b1;
    @(posedge clk);
    #1;
    d_cyc = cyc;
    done  = 1'b0;
  endtask

  // Exactly one result, 3 edges after the last sample, with the given values.
  task automatic chk_one(input string tag, input int ei, input int eq, input int es);
    check({tag, "_count"}, en_cyc.size(), 1);
    if (en_cyc.size() >= 1) begin
      check({tag, "_latency"}, en_cyc[0] - last_acc, 3);
      check({tag, "_out_i"}, en_i[0], ei);
      check({tag, "_out_q"}, en_q[0], eq);
      check({tag, "_short"}, en_s[0], es);
    end
  endtask

  initial begin
    in_data_i = '0; in_data_q = '0; in_w_i = '0; in_w_q = '0;
    in_en = 1'b0; done = 1'b0; rstb = 1'b0;

    // Reset state.
    do_reset();
    check("rst_out_en", int'(out_en), 0);
    check("rst_out_done", int'(out_done), 0);
    check("rst_out_short", int'(out_short), 0);
    check("rst_out_i", int'(out_data_i), 0);
    check("rst_out_q", int'(out_data_q), 0);

    // Full burst: 12 * 2047*7 = 171948 -> 168.
    burst(12, 2047, 0, 7, 0);
    tick(8);
    chk_one("full", 168, 0, 0);
    check("hold_out_i", int'(out_data_i), 168);
    check("hold_out_en", int'(out_en), 0);

    // Negative saturation: pr = -30705, pi = -2047 per sample.
    clr();
    burst(12, 2047, 2047, -8, 7);
    tick(8);
    chk_one("negsat", -256, -24, 0);

    // Positive saturation: pr = 30720, pi = 2048 per sample.
    clr();
    burst(12, -2048, -2048, -8, 7);
    tick(8);
    chk_one("possat", 255, 24, 0);

    // Short burst: 5 * 1024 = 5120 -> 5.
    clr();
    burst(5, 1024, 0, 1, 0);
    tick(8);
    chk_one("short", 5, 0, 1);

    // 24 continuous samples: two back-to-back bursts.
    clr();
    burst(12, 2047, 0, 7, 0);
    l12 = last_acc;
    burst(12, 2047, 0, 7, 0);
    tick(8);
    check("b2b_count", en_cyc.size(), 2);
    if (en_cyc.size() >= 2) begin
      check("b2b_latency", en_cyc[0] - l12, 3);
      check("b2b_spacing", en_cyc[1] - en_cyc[0], 12);
      check("b2b_short0", en_s[0], 0);
      check("b2b_short1", en_s[1], 0);
      check("b2b_out_i0", en_i[0], 168);
      check("b2b_out_i1", en_i[1], 168);
    end

    // Reset after the 6th sample discards the burst.
    clr();
    burst(6, 2047, 0, 7, 0);
    do_reset();
    tick(8);
    check("rstmid_count", en_cyc.size(), 0);
    burst(12, 2047, 0, 7, 0);
    tick(8);
    chk_one("post_rst", 168, 0, 0);

    // Ten bursts 3 idle cycles apart, then done 50 cycles after the last one.
    clr();
    for (int b = 0; b < 10; b++) begin
      burst(12, 2047, 0, 7, 0);
      tick(3);
    end
    tick(47);
    check("multi_count", en_cyc.size(), 10);
    for (int k = 1; k < 10; k++)
      if (en_cyc.size() > k) check($sformatf("multi_spacing%0d", k), en_cyc[k] - en_cyc[k-1], 15);
    if (en_cyc.size() >= 10) begin
      check("multi_out_i0", en_i[0], 168);
      check("multi_out_i9", en_i[9], 168);
    end
    pulse_done();
    tick(5);
    check("multi_done_count", dn_cyc.size(), 1);
    if (dn_cyc.size() >= 1) check("multi_done_edge", dn_cyc[0] - d_cyc, 1);

    // FIN ignores samples and further done pulses.
    burst(12, 2047, 0, 7, 0);
    pulse_done();
    tick(20);
    check("fin_en_count", en_cyc.size(), 10);
    check("fin_done_count", dn_cyc.size(), 1);

    // Reset in FLUSH discards the pending result and out_done.
    do_reset();
    burst(2, 2047, 0, 7, 0);
    samp(2047, 0, 7, 0, 1'b1);
    do_reset();
    tick(10);
    check("rstflush_en", en_cyc.size(), 0);
    check("rstflush_done", dn_cyc.size(), 0);

    // Done coincident with the 12th sample.
    burst(11, 2047, 0, 7, 0);
    samp(2047, 0, 7, 0, 1'b1);
    tick(8);
    chk_one("donecoin", 168, 0, 0);
    check("donecoin_done_count", dn_cyc.size(), 1);
    if (dn_cyc.size() >= 1) check("donecoin_done_edge", dn_cyc[0] - last_acc, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
